// File: rtl/inst_rom_arbiter.sv
// inst_rom_arbiter: shares the single combinational instruction-ROM read port
// between the IF-stage fetch path and a registered debug read port.
//
// Build option: ROM_ARB_STARVE_GUARD_EN
//   defined   -> after MAX_FETCH_RUN consecutive fetch wins with debug pending,
//                debug is forced in and fetch stalls for that one cycle.
//   undefined -> strict fetch priority; debug is served only when fetch is idle.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   fetch_ce_i/addr_i   fetch request and byte address
//   fetch_inst_o        fetch instruction (combinational, grant cycle)
//   stallreq_fetch_o    fetch requested but not granted (combinational)
//   dbg_req_i/addr_i    debug read request (held until ack) and byte address
//   dbg_ack_o           one-cycle pulse, dbg_inst_o/dbg_err_o valid
//   dbg_inst_o/err_o    registered debug read data / address error
//   rom_ce_o/addr_o     ROM chip enable and byte address (combinational)
//   rom_inst_i          ROM read data (combinational)
module inst_rom_arbiter #(
  parameter int unsigned MAX_FETCH_RUN = 8,
  parameter int unsigned ROM_WORDS     = 131071
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_ce_i,
  input  logic [31:0] fetch_addr_i,
  output logic [31:0] fetch_inst_o,
  output logic        stallreq_fetch_o,
  input  logic        dbg_req_i,
  input  logic [31:0] dbg_addr_i,
  output logic        dbg_ack_o,
  output logic [31:0] dbg_inst_o,
  output logic        dbg_err_o,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i
);

  localparam int unsigned WordIdxW = 30;
  localparam logic [WordIdxW-1:0] RomWordsW = WordIdxW'(ROM_WORDS);

  // Elaboration-time range check of the run limit (4-bit counter).
  if (MAX_FETCH_RUN < 1 || MAX_FETCH_RUN > 15) begin : g_bad_max_fetch_run
    $error("inst_rom_arbiter: MAX_FETCH_RUN must be in 1..15");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic        dbg_grant, fetch_grant, addr_ok, force_dbg;
  logic        dbg_ack_q, dbg_ack_d;
  logic [31:0] dbg_inst_q, dbg_inst_d;
  logic        dbg_err_q, dbg_err_d;

`ifdef ROM_ARB_STARVE_GUARD_EN
  localparam int unsigned RunW = 4;
  localparam logic [RunW-1:0] RunMax = RunW'(MAX_FETCH_RUN);

  logic [RunW-1:0] run_cnt_q, run_cnt_d;

  assign force_dbg = (run_cnt_q == RunMax);

  // Count fetch wins while debug waits; clear once debug is served or gone.
  always_comb begin
    run_cnt_d = run_cnt_q;
    if (!dbg_req_i || dbg_grant) begin
      run_cnt_d = '0;
    end else if (fetch_grant && (state_q == IDLE) && (run_cnt_q != RunMax)) begin
      run_cnt_d = run_cnt_q + RunW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt_q <= '0;
    end else begin
      run_cnt_q <= run_cnt_d;
    end
  end
`else
  assign force_dbg = 1'b0;
`endif

  // Word-aligned and inside the ROM.
  assign addr_ok = (dbg_addr_i[1:0] == 2'b00) && (dbg_addr_i[31:2] < RomWordsW);

  // Grant, ROM port muxing and next state; reset forces everything idle.
  always_comb begin
    state_d          = state_q;
    dbg_grant        = 1'b0;
    fetch_grant      = 1'b0;
    rom_ce_o         = 1'b0;
    rom_addr_o       = '0;
    fetch_inst_o     = '0;
    stallreq_fetch_o = 1'b0;
    dbg_ack_d        = 1'b0;
    dbg_inst_d       = dbg_inst_q;
    dbg_err_d        = dbg_err_q;

    if (!rst) begin
      if ((state_q == IDLE) && dbg_req_i && (!fetch_ce_i || force_dbg)) begin
        dbg_grant = 1'b1;
      end else if (fetch_ce_i) begin
        fetch_grant = 1'b1;
      end

      if (fetch_grant) begin
        rom_ce_o     = 1'b1;
        rom_addr_o   = fetch_addr_i;
        fetch_inst_o = rom_inst_i;
      end

      if (dbg_grant) begin
`ifdef ROM_ARB_STARVE_GUARD_EN
        stallreq_fetch_o = fetch_ce_i;
`endif
        dbg_ack_d = 1'b1;
        if (addr_ok) begin
          rom_ce_o   = 1'b1;
          rom_addr_o = dbg_addr_i;
          dbg_inst_d = rom_inst_i;
          dbg_err_d  = 1'b0;
        end else begin
          dbg_inst_d = '0;
          dbg_err_d  = 1'b1;
        end
      end

      unique case (state_q)
        IDLE:    if (dbg_grant) state_d = RESP;
        RESP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dbg_ack_q  <= 1'b0;
      dbg_inst_q <= '0;
      dbg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dbg_ack_q  <= dbg_ack_d;
      dbg_inst_q <= dbg_inst_d;
      dbg_err_q  <= dbg_err_d;
    end
  end

  assign dbg_ack_o  = dbg_ack_q;
  assign dbg_inst_o = dbg_inst_q;
  assign dbg_err_o  = dbg_err_q;

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Directed bench for inst_rom_arbiter; debug responses go through a scoreboard
// queue (pushed at grant, popped when dbg_ack_o is seen).
module tb_inst_rom_arbiter;

  localparam int unsigned ROM_WORDS = 131071;

  logic        clk;
  logic        rst;
  logic        fetch_ce_i;
  logic [31:0] fetch_addr_i;
  logic [31:0] fetch_inst_o;
  logic        stallreq_fetch_o;
  logic        dbg_req_i;
  logic [31:0] dbg_addr_i;
  logic        dbg_ack_o;
  logic [31:0] dbg_inst_o;
  logic        dbg_err_o;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_inst_i;

  typedef struct {
    logic [31:0] inst;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  inst_rom_arbiter #(
    .MAX_FETCH_RUN(8),
    .ROM_WORDS    (ROM_WORDS)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_ce_i      (fetch_ce_i),
    .fetch_addr_i    (fetch_addr_i),
    .fetch_inst_o    (fetch_inst_o),
    .stallreq_fetch_o(stallreq_fetch_o),
    .dbg_req_i       (dbg_req_i),
    .dbg_addr_i      (dbg_addr_i),
    .dbg_ack_o       (dbg_ack_o),
    .dbg_inst_o      (dbg_inst_o),
    .dbg_err_o       (dbg_err_o),
    .rom_ce_o        (rom_ce_o),
    .rom_addr_o      (rom_addr_o),
    .rom_inst_i      (rom_inst_i)
  );

  // ROM model
  assign rom_inst_i = ~rom_addr_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  // Advance one cycle, then check any ack against the scoreboard.
  task automatic step();
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    if (dbg_ack_o === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_ack observed=1 expected=0 cycle=%0d", cyc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk32("ack_data", dbg_inst_o, e.inst);
        chk1("ack_err", dbg_err_o, e.err);
        chk32("ack_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  endtask

  task automatic push_exp(input logic [31:0] inst, input logic err);
    exp_t e;
    e.inst = inst;
    e.err  = err;
    e.cyc  = cyc + 1;
    sb.push_back(e);
  endtask

  initial begin
    rst          = 1'b1;
    fetch_ce_i   = 1'b1;
    fetch_addr_i = 32'h40;
    dbg_req_i    = 1'b0;
    dbg_addr_i   = '0;
    step();
    step();
    #1;
    // Reset state and forced combinational outputs
    chk1("rst_ack", dbg_ack_o, 1'b0);
    chk32("rst_inst", dbg_inst_o, 32'h0);
    chk1("rst_err", dbg_err_o, 1'b0);
    chk1("rst_rom_ce", rom_ce_o, 1'b0);
    chk32("rst_fetch_inst", fetch_inst_o, 32'h0);

    // 1. fetch only, zero latency
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      fetch_ce_i   = 1'b1;
      fetch_addr_i = 32'(4 * i);
      #1;
      chk32("fetch_inst", fetch_inst_o, ~(32'(4 * i)));
      chk32("fetch_rom_addr", rom_addr_o, 32'(4 * i));
      chk1("fetch_stall", stallreq_fetch_o, 1'b0);
    end

    // 2. debug read with fetch idle
    step();
    fetch_ce_i = 1'b0;
    dbg_req_i  = 1'b1;
    dbg_addr_i = 32'h10;
    #1;
    chk32("dbg_rom_addr", rom_addr_o, 32'h10);
    chk1("dbg_rom_ce", rom_ce_o, 1'b1);
    chk32("dbg_fetch_inst_zero", fetch_inst_o, 32'h0);
    push_exp(32'hFFFF_FFEF, 1'b0);
    step();
    chk1("resp_no_regrant", rom_ce_o, 1'b0);
    step();
    dbg_req_i = 1'b0;
    step();
    chk1("ack_single", dbg_ack_o, 1'b0);
    chk32("dbg_inst_hold", dbg_inst_o, 32'hFFFF_FFEF);

    // 3. debug pending under continuous fetch
    dbg_req_i  = 1'b1;
    dbg_addr_i = 32'h20;
    fetch_ce_i = 1'b1;
`ifdef ROM_ARB_STARVE_GUARD_EN
    for (int i = 0; i < 8; i++) begin
      fetch_addr_i = 32'h100 + 32'(4 * i);
      #1;
      chk32("run_fetch_inst", fetch_inst_o, ~(32'h100 + 32'(4 * i)));
      chk1("run_stall", stallreq_fetch_o, 1'b0);
      step();
    end
    fetch_addr_i = 32'h120;
    #1;
    chk1("forced_stall", stallreq_fetch_o, 1'b1);
    chk32("forced_rom_addr", rom_addr_o, 32'h20);
    chk32("forced_fetch_inst", fetch_inst_o, 32'h0);
    push_exp(32'hFFFF_FFDF, 1'b0);
    step();
    chk1("post_force_stall", stallreq_fetch_o, 1'b0);
    step();
    dbg_req_i = 1'b0;
`else
    for (int i = 0; i < 12; i++) begin
      fetch_addr_i = 32'h100 + 32'(4 * i);
      #1;
      chk32("strict_fetch_inst", fetch_inst_o, ~(32'h100 + 32'(4 * i)));
      chk1("strict_stall", stallreq_fetch_o, 1'b0);
      step();
    end
    fetch_ce_i = 1'b0;
    #1;
    chk32("strict_dbg_rom_addr", rom_addr_o, 32'h20);
    push_exp(32'hFFFF_FFDF, 1'b0);
    step();
    step();
    dbg_req_i = 1'b0;
`endif
    fetch_ce_i = 1'b0;
    step();

    // 4. last valid word, then misaligned and out-of-range addresses
    dbg_req_i  = 1'b1;
    dbg_addr_i = 32'((ROM_WORDS - 1) * 4);
    #1;
    chk1("last_word_rom_ce", rom_ce_o, 1'b1);
    push_exp(~(32'((ROM_WORDS - 1) * 4)), 1'b0);
    step();
    step();
    dbg_addr_i = 32'h6;
    #1;
    chk1("misalign_rom_ce", rom_ce_o, 1'b0);
    push_exp(32'h0, 1'b1);
    step();
    step();
    dbg_addr_i = 32'(ROM_WORDS * 4);
    #1;
    chk1("oor_rom_ce", rom_ce_o, 1'b0);
    push_exp(32'h0, 1'b1);
    step();
    step();
    dbg_req_i = 1'b0;
    step();

    // 5. reset in the debug grant cycle
    rst          = 1'b1;
    dbg_req_i    = 1'b1;
    dbg_addr_i   = 32'h40;
    fetch_ce_i   = 1'b1;
    fetch_addr_i = 32'h80;
    #1;
    chk1("rstg_rom_ce", rom_ce_o, 1'b0);
    chk32("rstg_rom_addr", rom_addr_o, 32'h0);
    chk32("rstg_fetch_inst", fetch_inst_o, 32'h0);
    chk1("rstg_stall", stallreq_fetch_o, 1'b0);
    step();
    rst        = 1'b0;
    fetch_ce_i = 1'b0;
    #1;
    chk1("rstg_no_ack", dbg_ack_o, 1'b0);
    chk1("rstg_err_cleared", dbg_err_o, 1'b0);
    chk32("rstg_inst_cleared", dbg_inst_o, 32'h0);
    chk32("reserve_rom_addr", rom_addr_o, 32'h40);
    push_exp(32'hFFFF_FFBF, 1'b0);
    step();
    step();
    dbg_req_i = 1'b0;
    step();
    step();

    chk32("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
